// File: rtl/uart_pkg.sv
// Shared UART types and helpers: FSM state encoding, line levels, default widths, parity.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  localparam int unsigned DIV_W_DEF = 16;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR unchanged.
  localparam int unsigned PAR_MAX_W = 16;

  function automatic logic parity_of(input logic [PAR_MAX_W-1:0] data,
                                     input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter: load with div starts a period of exactly div cycles
// (div of 0 is treated as 1); bit_end_o is high on the last cycle of the period.
module uart_bit_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             bit_end_o
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= (div_i == '0) ? '0 : div_i - DIV_W'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_core.sv
// Single-clock UART transmitter: start, DATA_W bits LSB-first, optional parity, 1/2 stop bits.
// Define UART_TX_PARITY_EN to add the parity_en_i/parity_odd_i ports and the PARITY bit.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = DIV_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DIV_W-1:0]  baud_div_i,
  input  logic              stop2_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wr_i,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic              txd_o
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              txd_q, txd_d;
  logic              done_q, done_d;

  logic [DIV_W-1:0]  div_q;
  logic              stop2_q;
`ifdef UART_TX_PARITY_EN
  logic              par_en_q;
  logic              par_bit_q;
`endif

  logic              accept;
  logic              bit_end;
  logic              timer_load;
  logic [DIV_W-1:0]  div_in;
  logic [DIV_W-1:0]  timer_div;

  assign accept = wr_i && (state_q == IDLE);
  assign div_in = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;

  // The accept edge must load the timer with the incoming divisor, since div_q
  // only takes it on that same edge; later bits reload from the latched copy.
  assign timer_load = accept || ((state_q != IDLE) && bit_end);
  assign timer_div  = accept ? div_in : div_q;

  uart_bit_timer #(
    .DIV_W(DIV_W)
  ) u_bit_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (timer_load),
    .div_i    (timer_div),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q     <= '0;
      stop2_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else if (accept) begin
      div_q     <= div_in;
      stop2_q   <= stop2_i;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= parity_en_i;
      par_bit_q <= parity_of(PAR_MAX_W'(data_i), parity_odd_i);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= LINE_IDLE;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
    end
  end

  // txd is registered, so each branch computes the level of the bit being entered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        txd_d = LINE_IDLE;
        if (accept) begin
          state_d    = START;
          txd_d      = LINE_START;
          shift_d    = data_i;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          txd_d   = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = PARITY;
              txd_d   = par_bit_q;
            end else begin
              state_d = STOP;
              txd_d   = LINE_IDLE;
            end
`else
            state_d = STOP;
            txd_d   = LINE_IDLE;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          txd_d   = LINE_IDLE;
        end
      end
`endif

      STOP: begin
        txd_d = LINE_IDLE;
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = LINE_IDLE;
      end
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign txd_o  = txd_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Randomized self-checking bench for uart_tx_core; expected line levels come from a
// frame-level model (bit list expanded by the divisor). Honours UART_TX_PARITY_EN.
module tb_uart_tx_core;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0]  data;
    int unsigned div;
    bit          stop2;
    bit          pen;
    bit          podd;
  } cfg_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [DIV_W-1:0]  baud_div;
  logic              stop2;
  logic [DATA_W-1:0] data;
  logic              wr;
`ifdef UART_TX_PARITY_EN
  logic              parity_en;
  logic              parity_odd;
`endif
  logic              busy;
  logic              done;
  logic              txd;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  uart_tx_core #(
    .DATA_W(DATA_W),
    .DIV_W (DIV_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .baud_div_i  (baud_div),
    .stop2_i     (stop2),
    .data_i      (data),
    .wr_i        (wr),
`ifdef UART_TX_PARITY_EN
    .parity_en_i (parity_en),
    .parity_odd_i(parity_odd),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .txd_o       (txd)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic cfg_t mk(input logic [7:0] d, input int unsigned div, input bit s2,
                              input bit pen, input bit podd);
    cfg_t c;
    c.data  = d;
    c.div   = div;
    c.stop2 = s2;
    c.pen   = pen & PAR_ON;
    c.podd  = podd;
    return c;
  endfunction

  function automatic cfg_t rand_cfg();
    return mk(8'($urandom), $urandom_range(0, 4), 1'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  // Frame model: symbol list is start, data LSB-first, optional parity, stop bits.
  function automatic int unsigned n_bits(input cfg_t c);
    return 1 + DATA_W + (c.pen ? 1 : 0) + (c.stop2 ? 2 : 1);
  endfunction

  function automatic int unsigned eff_div(input cfg_t c);
    return (c.div == 0) ? 1 : c.div;
  endfunction

  function automatic bit exp_bit(input cfg_t c, input int unsigned idx);
    bit ones_odd;
    if (idx == 0) return 1'b0;
    if (idx <= DATA_W) return c.data[idx-1];
    ones_odd = ($countones(c.data) % 2) == 1;
    if (c.pen && idx == DATA_W + 1) return c.podd ? !ones_odd : ones_odd;
    return 1'b1;
  endfunction

  task automatic drive(input cfg_t c, input logic w);
    data     = c.data;
    baud_div = DIV_W'(c.div);
    stop2    = c.stop2;
    wr       = w;
`ifdef UART_TX_PARITY_EN
    parity_en  = c.pen;
    parity_odd = c.podd;
`endif
  endtask

  // Sends one frame and checks every cycle of it. chain_out keeps wr high with the
  // next frame's inputs so that frame is accepted in the done cycle.
  task automatic run_frame(input cfg_t cur, input bit chained_in, input bit chain_out,
                           input cfg_t nxt);
    int unsigned eff, len;
    cfg_t junk;
    eff  = eff_div(cur);
    len  = n_bits(cur) * eff;
    junk = mk(8'h12, 8, !cur.stop2, !cur.pen, !cur.podd);
    if (!chained_in) begin
      @(negedge clk);
      check_eq("idle_busy", busy, 1'b0);
      drive(cur, 1'b1);
    end
    @(posedge clk);
    for (int unsigned c = 0; c < len; c++) begin
      @(negedge clk);
      check_eq("txd", txd, exp_bit(cur, c / eff));
      check_eq("busy", busy, 1'b1);
      check_eq("done_early", done, 1'b0);
      if (c == 0) begin
        if (chain_out) drive(nxt, 1'b1);
        else drive(junk, 1'b0);
      end else if (!chain_out && c == 1) begin
        wr = 1'b1;
      end else if (!chain_out && c == 2) begin
        wr = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("done_pulse", done, 1'b1);
    check_eq("busy_end", busy, 1'b0);
    check_eq("txd_end", txd, 1'b1);
    if (!chain_out) begin
      @(negedge clk);
      check_eq("done_once", done, 1'b0);
      check_eq("txd_idle", txd, 1'b1);
      check_eq("no_resend", busy, 1'b0);
    end
  endtask

  cfg_t cur, nxt, none;
  bit   chained, ch;

  initial begin
    none = mk(8'h00, 1, 1'b0, 1'b0, 1'b0);
    rst  = 1'b1;
    drive(none, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_txd", txd, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    rst = 1'b0;

    run_frame(mk(8'h55, 4, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, none);
    run_frame(mk(8'hA3, 1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, none);
    run_frame(mk(8'hA3, 0, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, none);
    run_frame(mk(8'h00, 2, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, mk(8'hFF, 2, 1'b0, 1'b0, 1'b0));
    run_frame(mk(8'hFF, 2, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, none);
    run_frame(mk(8'h55, 4, 1'b0, 1'b1, 1'b0), 1'b0, 1'b0, none);
    run_frame(mk(8'h55, 4, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, none);

    // Reset during data bit 3 of a 0x55/div 4 frame.
    cur = mk(8'h55, 4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(cur, 1'b1);
    @(posedge clk);
    for (int unsigned c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) wr = 1'b0;
      check_eq("pre_rst_txd", txd, exp_bit(cur, c / 4));
      if (c == 17) rst = 1'b1;
    end
    @(negedge clk);
    check_eq("abort_txd", txd, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    rst = 1'b0;
    for (int unsigned c = 0; c < 45; c++) begin
      @(negedge clk);
      check_eq("post_rst_done", done, 1'b0);
      check_eq("post_rst_txd", txd, 1'b1);
    end
    run_frame(mk(8'hC6, 3, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, none);

    chained = 1'b0;
    cur     = rand_cfg();
    for (int unsigned i = 0; i < 40; i++) begin
      nxt = rand_cfg();
      ch  = (i < 39) && ($urandom_range(0, 1) == 1);
      run_frame(cur, chained, ch, nxt);
      chained = ch;
      cur     = nxt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Single-clock UART transmitter. It serialises one parallel word per frame onto txd_o: start bit, data LSB-first, optional parity, then 1 or 2 stop bits.
- Companion to the oversampling receiver. It drives the line that the receiver samples, e.g. in the HEX-display loopback top.
- Unlike the derived-clock transmitter, it runs on the system clock and uses an internal bit timer (clock-enable style).

Parameters:
DATA_W, 8, data bits per frame (5..9)
DIV_W, 16, width of the baud divisor

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, synchronous, active-high
baud_div_i  in  DIV_W  clk_i cycles per bit; latched at frame accept; 0 treated as 1
stop2_i  in  1  1 = two stop bits, 0 = one; latched at accept
data_i  in  DATA_W  word to send; latched at accept
wr_i  in  1  write request
busy_o  out  1  frame in progress; wr_i ignored while high
done_o  out  1  one-cycle pulse at frame end
txd_o  out  1  serial line, idle high, registered

Behaviour:
- Reset (rst_i high at a clk_i edge): state IDLE, txd_o=1, busy_o=0, done_o=0, shift register and counters cleared.
- Reset mid-frame: abort on the same edge; line returns high; no done_o pulse.
- Accept: wr_i && !busy_o at edge N.
  - Latch data_i, baud_div_i (0 becomes 1) and stop2_i.
  - After edge N: txd_o=0 (start bit) and busy_o=1.
- wr_i while busy_o=1: dropped, no queue. Input changes after accept have no effect on the current frame.
- Bit timer: down-counter loaded with div-1 on entry to each bit. Each bit lasts exactly div cycles; bit_end asserts when the count reaches 0.
- FSM states and transitions:
  - IDLE→START on accept.
  - START→DATA on bit_end.
  - DATA: shift right, txd_o=shift[0]; after DATA_W bits go to PARITY (feature on) or STOP.
  - PARITY→STOP on bit_end.
  - STOP: txd_o=1 for 1 or 2 bit periods, then →IDLE.
- Exit from STOP: busy_o=0 and done_o=1 for exactly one cycle.
- Frame length: (1+DATA_W+P+S)*div cycles, where P is the parity bit (0/1) and S is the stop-bit count.
- Back-to-back: with wr_i held high, the next accept occurs in the first IDLE cycle. Minimum inter-frame gap is therefore 1 clk of extra high beyond the stop bits.
- The bit-period count is exact across bit boundaries: no cycle is lost or added at state transitions.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - Adds ports parity_en_i (1) and parity_odd_i (1), both latched at accept.
  - When parity_en_i=1, a PARITY bit follows the data bits. Its value is XOR(data) for even parity, or ~XOR(data) when parity_odd_i=1.
- Undefined:
  - Ports and PARITY state are absent; the frame goes straight from DATA to STOP.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Line level constants LINE_IDLE=1, LINE_START=0.
  - Default DIV_W.
  - A parity function.
- Sub-module uart_bit_timer:
  - Loadable down-counter with inputs load/div and output bit_end.
  - Reusable by a future single-clock receiver.

Test Plan:
- rst_i low, baud_div_i=4, stop2_i=0, wr_i pulse with data_i=0x55 → txd_o per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1. busy_o high 40 cycles. done_o pulse at cycle 40. Then txd_o=1.
- data_i=0xA3, baud_div_i=1, stop2_i=1 → txd_o: 0,1,1,0,0,0,1,0,1,1,1 (11 cycles). done_o after second stop bit.
- wr_i held high, data 0x00 then 0xFF, div=2 → second start bit begins exactly 1 clk after the first frame's stop bit. Second frame's data bits all 1.
- During frame 0x55, pulse wr_i with 0x12 and change baud_div_i to 8 → frame unaffected; 0x12 never sent.
- rst_i asserted during data bit 3 → txd_o=1 and busy_o=0 after that edge; no done_o. A new frame after reset is clean.
- UART_TX_PARITY_EN defined, data 0x55, div=4:
  - Even parity → parity bit 0.
  - Odd parity → parity bit 1.
  - Frame length 44 cycles.
- baud_div_i=0 → behaves identically to baud_div_i=1.
